// File: rtl/epu_mem_pkg.sv
// Shared types and helpers for the EPU memory-port arbitration logic.
package epu_mem_pkg;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int NREQ_DEF   = 2;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int ID_W       = (clog2(NREQ_DEF) < 1) ? 1 : clog2(NREQ_DEF);

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester ids for reads still awaiting their response.
module arb_tag_fifo
    import epu_mem_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [W-1:0]                din,
    input  logic                        pop,
    output logic [W-1:0]                dout,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one bank_sram port; read responses are routed back
// to their issuer through an in-order tag FIFO.
//   state      | meaning
//   ARB_OPEN   | grant chosen round-robin from rr_ptr among eligible requesters
//   ARB_LOCKED | a grant was stalled by m_req_ready=0; held on locked_id until accepted
module sram_port_arbiter
    import epu_mem_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUTS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            rq_v,
    input  logic [NREQ-1:0]            rq_we,
    input  logic [NREQ*ADDR_W-1:0]     rq_addr,
    input  logic [NREQ*DATA_W-1:0]     rq_wdata,
    output logic [NREQ-1:0]            rq_ready,
    output logic [NREQ-1:0]            rs_v,
    output logic [DATA_W-1:0]          rs_rdata,
    output logic                       m_req_v,
    output logic                       m_req_we,
    output logic [ADDR_W-1:0]          m_req_addr,
    output logic [DATA_W-1:0]          m_req_wdata,
    input  logic                       m_req_ready,
    input  logic                       m_rsp_v,
    input  logic [DATA_W-1:0]          m_rsp_rdata,
    output logic [clog2(OUTS+1)-1:0]   outs_cnt,
    output logic                       err_unexp
);

    localparam int GID_W = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
    localparam int CNT_W = clog2(OUTS + 1);

    arb_state_t       state_q, state_d;
    logic [GID_W-1:0] locked_id_q, rr_ptr_q, grant, scan_idx, head_id;
    logic [NREQ-1:0]  eligible;
    logic             grant_v, accept, err_q;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Reads need a free tag slot; a pop in this cycle does not count as one.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = rq_v[i] & (rq_we[i] | (outs_cnt < CNT_W'(OUTS)));
        end
    end

    always_comb begin
        grant_v  = 1'b0;
        grant    = '0;
        scan_idx = '0;
        state_d  = state_q;
        if (state_q == ARB_LOCKED) begin
            grant_v = 1'b1;
            grant   = locked_id_q;
        end else begin
            // Scan downward so the last hit is the one closest to rr_ptr.
            for (int k = NREQ - 1; k >= 0; k--) begin
                scan_idx = GID_W'((int'(rr_ptr_q) + k) % NREQ);
                if (eligible[scan_idx]) begin
                    grant_v = 1'b1;
                    grant   = scan_idx;
                end
            end
        end
        accept = grant_v & m_req_ready;
        if (grant_v && !m_req_ready) state_d = ARB_LOCKED;
        else if (accept)             state_d = ARB_OPEN;
    end

    always_comb begin
        m_req_v     = grant_v;
        m_req_we    = 1'b0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        rq_ready    = '0;
        if (grant_v) begin
            m_req_we        = rq_we[grant];
            m_req_addr      = rq_addr[grant*ADDR_W +: ADDR_W];
            m_req_wdata     = rq_wdata[grant*DATA_W +: DATA_W];
            rq_ready[grant] = m_req_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_OPEN;
            locked_id_q <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_v && !m_req_ready) locked_id_q <= grant;
            if (accept) rr_ptr_q <= (grant == GID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
            if (m_rsp_v && fifo_empty) err_q <= 1'b1;
        end
    end

    assign fifo_push = accept & ~m_req_we & ~fifo_full;
    assign fifo_pop  = m_rsp_v & ~fifo_empty;

    arb_tag_fifo #(
        .W     (GID_W),
        .DEPTH (OUTS)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (grant),
        .pop   (fifo_pop),
        .dout  (head_id),
        .count (outs_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rs_v = '0;
        if (fifo_pop) rs_v[head_id] = 1'b1;
    end

    assign rs_rdata  = m_rsp_rdata;
    assign err_unexp = err_q;

endmodule
